// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler: round-robin scheduler that feeds one serial sequence detector
// from NUM_REQ frame requesters and reports hit count and first-hit position per frame.
module seq_detect_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int FRAME_W = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*FRAME_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         seq_in,
    output logic                         det_clr,
    input  logic                         detect,
    output logic                         done_valid,
    input  logic                         done_ready,
    output logic [$clog2(NUM_REQ)-1:0]   done_id,
    output logic [CNT_W-1:0]             done_hits,
    output logic [$clog2(FRAME_W):0]     done_pos
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int POS_W = $clog2(FRAME_W) + 1;
    localparam int T_W   = $clog2(FRAME_W + DET_LAT + 1) + 1;

    typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} state_t;

    state_t            state, nxt;
    logic [ID_W-1:0]   rr_ptr, grant_id, id;
    logic              found;
    logic [FRAME_W-1:0] sh;
    logic [T_W-1:0]    t;
    logic [CNT_W-1:0]  hits;
    logic [POS_W-1:0]  pos;
    logic              in_win;

    // Descending offset scan so the requester closest to rr_ptr is the last writer.
    always_comb begin
        int j;
        found = 1'b0;
        grant_id = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            j = (j >= NUM_REQ) ? j - NUM_REQ : j;
            if (req_valid[j]) begin
                found = 1'b1;
                grant_id = ID_W'(j);
            end
        end
    end

    assign req_ready  = (state == IDLE && found) ? (NUM_REQ'(1) << grant_id) : '0;
    assign det_clr    = (state == CLEAR);
    assign done_valid = (state == REPORT);
    assign done_id    = id;
    assign done_hits  = hits;
    assign done_pos   = pos;
    assign in_win     = (state == SHIFT || state == DRAIN) && (t >= T_W'(DET_LAT));

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = found ? CLEAR : IDLE;
            CLEAR:   nxt = SHIFT;
            SHIFT:   nxt = (t == T_W'(FRAME_W - 1)) ? ((DET_LAT > 0) ? DRAIN : REPORT) : SHIFT;
            DRAIN:   nxt = (t == T_W'(FRAME_W + DET_LAT - 1)) ? REPORT : DRAIN;
            REPORT:  nxt = done_ready ? IDLE : REPORT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr <= '0;
            id     <= '0;
            sh     <= '0;
            t      <= '0;
            hits   <= '0;
            pos    <= '1;
            seq_in <= 1'b0;
        end else begin
            seq_in <= 1'b0;
            if (state == IDLE && found) begin
                sh     <= req_data[grant_id*FRAME_W +: FRAME_W];
                id     <= grant_id;
                rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            // seq_in is loaded one edge ahead so it shows bit FRAME_W-1-k in SHIFT cycle k.
            if (state == CLEAR) begin
                hits   <= '0;
                pos    <= '1;
                t      <= '0;
                seq_in <= sh[FRAME_W-1];
                sh     <= sh << 1;
            end
            if (state == SHIFT || state == DRAIN)
                t <= t + 1'b1;
            if (state == SHIFT && t < T_W'(FRAME_W - 1)) begin
                seq_in <= sh[FRAME_W-1];
                sh     <= sh << 1;
            end
            if (in_win && detect) begin
                hits <= (hits == '1) ? hits : hits + 1'b1;
                pos  <= (pos == '1) ? POS_W'(t - T_W'(DET_LAT)) : pos;
            end
        end
    end
endmodule

// File: tb/tb_seq_detect_scheduler.sv
// tb_seq_detect_scheduler: directed bench with an overlapping "1011" detector model
// (one-cycle latency) and a second CNT_W=2 instance driven by a "1" detector.
module tb_seq_detect_scheduler;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_ready;
    logic [31:0] req_data;
    logic        seq_in, det_clr, detect, done_valid, done_ready;
    logic [1:0]  done_id;
    logic [3:0]  done_hits;
    logic [3:0]  done_pos;
    logic        force_det;
    logic [3:0]  hist;
    logic        det_q;

    logic [3:0]  req_valid2, req_ready2;
    logic [31:0] req_data2;
    logic        seq_in2, det_clr2, det2, done_valid2;
    logic [1:0]  done_id2;
    logic [1:0]  done_hits2;
    logic [3:0]  done_pos2;

    int n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;

    seq_detect_scheduler #(.NUM_REQ(4), .FRAME_W(8), .CNT_W(4), .DET_LAT(1)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .seq_in(seq_in), .det_clr(det_clr), .detect(detect), .done_valid(done_valid),
        .done_ready(done_ready), .done_id(done_id), .done_hits(done_hits), .done_pos(done_pos)
    );

    seq_detect_scheduler #(.NUM_REQ(4), .FRAME_W(8), .CNT_W(2), .DET_LAT(1)) dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_data(req_data2), .req_ready(req_ready2),
        .seq_in(seq_in2), .det_clr(det_clr2), .detect(det2), .done_valid(done_valid2),
        .done_ready(1'b1), .done_id(done_id2), .done_hits(done_hits2), .done_pos(done_pos2)
    );

    always_ff @(posedge clk) begin
        if (rst || det_clr) begin
            hist  <= '0;
            det_q <= 1'b0;
        end else begin
            hist  <= {hist[2:0], seq_in};
            det_q <= ({hist[2:0], seq_in} == 4'b1011);
        end
    end
    assign detect = det_q | force_det;

    always_ff @(posedge clk)
        det2 <= (rst || det_clr2) ? 1'b0 : seq_in2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int bound);
        int c = 0;
        while (!done_valid && c < bound) begin
            @(negedge clk);
            c++;
        end
        check("done_seen", done_valid, 1);
    endtask

    initial begin
        logic [7:0]  sbits;
        logic [3:0]  g_oh[5];
        int          g_cyc[5];
        int          ng, cyc, c;
        logic        seen, clr_bad;

        rst = 1'b1; req_valid = '0; req_data = '0; done_ready = 1'b1; force_det = 1'b0;
        req_valid2 = '0; req_data2 = '0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_seq_in", seq_in, 0);
        check("rst_det_clr", det_clr, 0);
        check("rst_done_valid", done_valid, 0);
        check("rst_done_id", done_id, 0);
        check("rst_done_hits", done_hits, 0);
        check("rst_done_pos", done_pos, 4'hF);
        rst = 1'b0;

        // Frame 1011_1011 from req0: two overlapping hits, first at bit 3.
        req_data[7:0] = 8'hBB; req_valid = 4'b0001;
        #1 check("t1_grant", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("t1_clr", det_clr, 1);
        check("t1_clr_seq", seq_in, 0);
        clr_bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            sbits[7-k] = seq_in;
            clr_bad |= det_clr;
        end
        check("t1_serial", sbits, 8'hBB);
        check("t1_clr_once", clr_bad, 0);
        @(negedge clk);
        check("t1_drain_seq", seq_in, 0);
        check("t1_drain_valid", done_valid, 0);
        @(negedge clk);
        check("t1_valid", done_valid, 1);
        check("t1_id", done_id, 0);
        check("t1_hits", done_hits, 2);
        check("t1_pos", done_pos, 3);
        @(negedge clk);

        // Reset in SHIFT cycle 4 aborts req3's frame with no report.
        req_data[31:24] = 8'hFF; req_valid = 4'b1000;
        #1 check("t6_grant", req_ready, 4'b1000);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("t6_shift4_seq", seq_in, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_seq", seq_in, 0);
        check("t6_valid", done_valid, 0);
        check("t6_clr", det_clr, 0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen |= done_valid | (req_ready != 0);
        end
        check("t6_no_report", seen, 0);

        // All requesters valid: grants 0,1,2,3,0 spaced 12 cycles (rr_ptr back at 0).
        req_data = '0; req_valid = 4'b1111;
        ng = 0; cyc = 0;
        #1;
        while (ng < 5 && cyc < 100) begin
            if (req_ready != 0) begin
                g_oh[ng] = req_ready;
                g_cyc[ng] = cyc;
                ng++;
            end
            if (ng < 5) begin
                @(negedge clk); #1;
                cyc++;
            end
        end
        check("t2_grant_count", ng, 5);
        check("t2_g0", g_oh[0], 4'b0001);
        check("t2_g1", g_oh[1], 4'b0010);
        check("t2_g2", g_oh[2], 4'b0100);
        check("t2_g3", g_oh[3], 4'b1000);
        check("t2_g4", g_oh[4], 4'b0001);
        for (int i = 1; i < 5; i++)
            check("t2_gap", g_cyc[i] - g_cyc[i-1], 12);
        @(posedge clk); #1 req_valid = '0;
        wait_done(30);
        @(negedge clk);

        // All-zero frame from req2; detect forced in CLEAR, SHIFT 0 and REPORT is ignored.
        req_data[23:16] = 8'h00; req_valid = 4'b0100;
        #1 check("t3_grant", req_ready, 4'b0100);
        @(posedge clk); #1 req_valid = '0;
        @(negedge clk);
        check("t3_clr", det_clr, 1);
        force_det = 1'b1;
        @(negedge clk);
        @(negedge clk);
        force_det = 1'b0;
        wait_done(20);
        check("t3_id", done_id, 2);
        check("t3_hits", done_hits, 0);
        check("t3_pos", done_pos, 4'hF);
        force_det = 1'b1;
        @(negedge clk);
        force_det = 1'b0;
        check("t3_after_hits", done_hits, 0);

        // Back-pressure in REPORT with req1 waiting; req1 granted right after handshake.
        req_data[7:0] = 8'h2D; req_data[15:8] = 8'h00; req_valid = 4'b0011; done_ready = 1'b0;
        #1 check("t5_grant0", req_ready, 4'b0001);
        @(posedge clk); #1 req_valid = 4'b0010;
        wait_done(20);
        for (int i = 0; i < 6; i++) begin
            check("t5_hold_valid", done_valid, 1);
            check("t5_hold_id", done_id, 0);
            check("t5_hold_hits", done_hits, 1);
            check("t5_hold_pos", done_pos, 5);
            check("t5_hold_ready", req_ready, 0);
            if (i < 5) @(negedge clk);
        end
        done_ready = 1'b1;
        @(negedge clk);
        check("t5_grant1", req_ready, 4'b0010);
        check("t5_idle_valid", done_valid, 0);
        @(posedge clk); #1 req_valid = '0;
        wait_done(20);
        check("t5_id1", done_id, 1);
        check("t5_hits1", done_hits, 0);
        @(negedge clk);

        // CNT_W=2 instance with a "1" detector: 8 hits saturate at 3, first at bit 0.
        req_data2[7:0] = 8'hFF; req_valid2 = 4'b0001;
        #1 check("t4_grant", req_ready2, 4'b0001);
        @(posedge clk); #1 req_valid2 = '0;
        c = 0;
        while (!done_valid2 && c < 30) begin
            @(negedge clk);
            c++;
        end
        check("t4_done_seen", done_valid2, 1);
        check("t4_id", done_id2, 0);
        check("t4_hits", done_hits2, 3);
        check("t4_pos", done_pos2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
